// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window, one
// pixel per enabled clock, emitting only windows that lie fully inside the frame.
module window3x3_gen #(
    parameter int unsigned IMG_WIDTH  = 256,
    parameter int unsigned IMG_HEIGHT = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Enable,
    input  logic [7:0] pixel_in,
    output logic [7:0] pixel_1,
    output logic [7:0] pixel_2,
    output logic [7:0] pixel_3,
    output logic [7:0] pixel_4,
    output logic [7:0] pixel_5,
    output logic [7:0] pixel_6,
    output logic [7:0] pixel_7,
    output logic [7:0] pixel_8,
    output logic [7:0] pixel_9,
    output logic       window_valid,
    output logic       frame_done
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColTwo  = ColW'(2);
    localparam logic [RowW-1:0] RowTwo  = RowW'(2);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [7:0]      win_q [9];
    logic [7:0]      win_d [9];
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    // lb0 holds line row-1, lb1 holds line row-2; neither is cleared by reset.
    logic [7:0]      lb0_q [IMG_WIDTH];
    logic [7:0]      lb1_q [IMG_WIDTH];
    logic [7:0]      lb_a, lb_b;
    logic            col_last, row_last;

    assign lb_a     = lb1_q[col_q];
    assign lb_b     = lb0_q[col_q];
    assign col_last = (col_q == ColLast);
    assign row_last = (row_q == RowLast);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (Enable) begin
            valid_d = (row_q >= RowTwo) && (col_q >= ColTwo);
            done_d  = row_last && col_last;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb_a;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb_b;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pixel_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && Enable) begin
            lb1_q[col_q] <= lb_b;
            lb0_q[col_q] <= pixel_in;
        end
    end

    assign pixel_1      = win_q[0];
    assign pixel_2      = win_q[1];
    assign pixel_3      = win_q[2];
    assign pixel_4      = win_q[3];
    assign pixel_5      = win_q[4];
    assign pixel_6      = win_q[5];
    assign pixel_7      = win_q[6];
    assign pixel_8      = win_q[7];
    assign pixel_9      = win_q[8];
    assign window_valid = valid_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: a 5x4 instance for the main scenarios and a 3x3 instance
// for the single-window border case.
module tb_window3x3_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       en, en3;
    logic [7:0] pix, pix3;
    logic [7:0] w [9];
    logic [7:0] q [9];
    logic       wv, fd, v3, d3;

    int n_checks = 0;
    int n_fail   = 0;

    int         vcount, dcount, vtotal, dtotal;
    logic [7:0] last_pix;
    bit         last_valid;
    int         last_r, last_c, last_off;

    always #5 clock = ~clock;

    window3x3_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut (
        .clock(clock), .reset(reset), .Enable(en), .pixel_in(pix),
        .pixel_1(w[0]), .pixel_2(w[1]), .pixel_3(w[2]),
        .pixel_4(w[3]), .pixel_5(w[4]), .pixel_6(w[5]),
        .pixel_7(w[6]), .pixel_8(w[7]), .pixel_9(w[8]),
        .window_valid(wv), .frame_done(fd)
    );

    window3x3_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clock(clock), .reset(reset), .Enable(en3), .pixel_in(pix3),
        .pixel_1(q[0]), .pixel_2(q[1]), .pixel_3(q[2]),
        .pixel_4(q[3]), .pixel_5(q[4]), .pixel_6(q[5]),
        .pixel_7(q[6]), .pixel_8(q[7]), .pixel_9(q[8]),
        .window_valid(v3), .frame_done(d3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window ending at (r,c) covers rows r-2..r and cols c-2..c of the 16*row+col+off pattern.
    task automatic check_win(input string tag, input int r, input int c, input int off);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s r%0d c%0d p%0d", tag, r, c, k + 1), {24'd0, w[k]},
                32'((16 * (r - 2 + k / 3) + (c - 2 + k % 3) + off) & 8'hff));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 9; k++) chk($sformatf("%s p%0d", tag, k + 1), {24'd0, w[k]}, 32'd0);
        chk({tag, " valid"}, {31'd0, wv}, 32'd0);
        chk({tag, " done"}, {31'd0, fd}, 32'd0);
    endtask

    task automatic send(input int r, input int c, input int off);
        bit ev, ed;
        en  = 1'b1;
        pix = 8'((16 * r + c + off) & 8'hff);
        @(posedge clock);
        #1;
        en = 1'b0;
        ev = (r >= 2) && (c >= 2);
        ed = (r == 3) && (c == 4);
        chk($sformatf("valid r%0d c%0d", r, c), {31'd0, wv}, {31'd0, ev});
        chk($sformatf("done r%0d c%0d", r, c), {31'd0, fd}, {31'd0, ed});
        if (wv === 1'b1) vcount++;
        if (fd === 1'b1) dcount++;
        if (ev) check_win("win", r, c, off);
        last_pix   = pix;
        last_valid = ev;
        last_r     = r;
        last_c     = c;
        last_off   = off;
    endtask

    task automatic idle();
        en = 1'b0;
        @(posedge clock);
        #1;
        chk("gap valid", {31'd0, wv}, 32'd0);
        chk("gap done", {31'd0, fd}, 32'd0);
        chk("gap hold p9", {24'd0, w[8]}, {24'd0, last_pix});
        if (last_valid) check_win("gap hold", last_r, last_c, last_off);
    endtask

    task automatic frame(input int off, input bit gaps);
        vcount = 0;
        dcount = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                send(r, c, off);
                if (gaps) repeat ($urandom_range(0, 2)) idle();
            end
        end
        chk("valid count", vcount, 32'd6);
        chk("done count", dcount, 32'd1);
        vtotal += vcount;
        dtotal += dcount;
    endtask

    initial begin
        vtotal = 0;
        dtotal = 0;
        // Power-up reset with a live Enable and all-ones pixel
        reset = 1'b1;
        en    = 1'b1;
        pix   = 8'hff;
        en3   = 1'b1;
        pix3  = 8'hff;
        repeat (3) begin
            @(posedge clock);
            #1;
            check_zero("por");
            chk("por dut3 p9", {24'd0, q[8]}, 32'd0);
            chk("por dut3 valid", {31'd0, v3}, 32'd0);
        end
        reset = 1'b0;
        en    = 1'b0;
        en3   = 1'b0;

        // 3x3 frame: exactly one window, coincident with frame_done
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                en3  = 1'b1;
                pix3 = 8'(16 * r + c);
                @(posedge clock);
                #1;
                en3 = 1'b0;
                chk($sformatf("3x3 valid r%0d c%0d", r, c), {31'd0, v3},
                    {31'd0, (r == 2 && c == 2)});
                chk($sformatf("3x3 done r%0d c%0d", r, c), {31'd0, d3},
                    {31'd0, (r == 2 && c == 2)});
            end
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("3x3 p%0d", k + 1), {24'd0, q[k]}, 32'(16 * (k / 3) + k % 3));

        // Continuous, gapped, then back-to-back with offset frame
        frame(0, 1'b0);
        frame(0, 1'b1);
        vtotal = 0;
        dtotal = 0;
        frame(0, 1'b0);
        frame(8'h80, 1'b0);
        chk("b2b valid total", vtotal, 32'd12);
        chk("b2b done total", dtotal, 32'd2);

        // Mid-frame reset after 9 pixels, then a clean frame
        for (int i = 0; i < 9; i++) send(i / 5, i % 5, 8'h40);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_zero("midrst");
        frame(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
